// File: rtl/alu_op_sequencer.sv
// Operand/opcode sequencer for the 8-bit ALU stage. It collects the bytes A, B and the opcode, drives the ALU, waits the settle time, captures the result and hands it downstream.
// Build option: defining ILLEGAL_OP_TRAP_EN traps opcodes above 8 and reports them on out_err.
module alu_op_sequencer #(
  parameter int DATA_W      = 8,
  parameter int OP_W        = 4,
  parameter int DEC_W       = 16,
  parameter int EXEC_CYCLES = 1
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              in_valid,
  output logic              in_ready,
  input  logic [DATA_W-1:0] in_data,
  output logic [DATA_W-1:0] alu_a,
  output logic [DATA_W-1:0] alu_b,
  output logic [DEC_W-1:0]  alu_opdec,
  input  logic              alu_neg,
  input  logic [DATA_W/2-1:0] alu_rl,
  input  logic [DATA_W/2-1:0] alu_rh,
  output logic              out_valid,
  input  logic              out_ready,
  output logic [DATA_W-1:0] out_result,
  output logic              out_neg,
  output logic              out_err,
  output logic              busy,
  output logic [7:0]        op_count,
  output logic [2:0]        dbg_state
);

  // Handshakes: a byte moves when in_valid && in_ready at a rising edge, and a result moves
  // when out_valid && out_ready at a rising edge. Neither ready depends on its own valid.

  typedef enum logic [2:0] {
    S_A    = 3'd0,
    S_B    = 3'd1,
    S_OP   = 3'd2,
    S_EXEC = 3'd3,
    S_RESP = 3'd4
  } state_t;

  localparam logic [7:0] CNT_LAST = 8'(EXEC_CYCLES - 1);

  state_t              state_q, state_d;
  logic [DATA_W-1:0]   a_q, a_d;
  logic [DATA_W-1:0]   b_q, b_d;
  logic [DEC_W-1:0]    opdec_q, opdec_d;
  logic [7:0]          cnt_q, cnt_d;
  logic [DATA_W-1:0]   result_q, result_d;
  logic                neg_q, neg_d;
  logic                err_q, err_d;
  logic [7:0]          op_count_q, op_count_d;
  logic                in_xfer;
  logic                op_illegal;

`ifdef ILLEGAL_OP_TRAP_EN
  assign op_illegal = (in_data[OP_W-1:0] > OP_W'(8));
`else
  assign op_illegal = 1'b0;
`endif

  assign in_ready = (state_q == S_A) || (state_q == S_B) || (state_q == S_OP);
  assign in_xfer  = in_valid && in_ready;

  always_comb begin
    state_d    = state_q;
    a_d        = a_q;
    b_d        = b_q;
    opdec_d    = opdec_q;
    cnt_d      = cnt_q;
    result_d   = result_q;
    neg_d      = neg_q;
    err_d      = err_q;
    op_count_d = op_count_q;
    case (state_q)
      S_A: begin
        if (in_xfer) begin
          a_d     = in_data;
          state_d = S_B;
        end
      end
      S_B: begin
        if (in_xfer) begin
          b_d     = in_data;
          state_d = S_OP;
        end
      end
      S_OP: begin
        if (in_xfer) begin
          if (op_illegal) begin
            // Trapped opcode: the ALU never sees it, so go straight to the response.
            opdec_d  = '0;
            result_d = '0;
            neg_d    = 1'b0;
            err_d    = 1'b1;
            state_d  = S_RESP;
          end else begin
            opdec_d = DEC_W'(1) << in_data[OP_W-1:0];
            cnt_d   = '0;
            state_d = S_EXEC;
          end
        end
      end
      S_EXEC: begin
        cnt_d = cnt_q + 8'd1;
        if (cnt_q == CNT_LAST) begin
          result_d = {alu_rh, alu_rl};
          neg_d    = alu_neg;
          err_d    = 1'b0;
          state_d  = S_RESP;
        end
      end
      S_RESP: begin
        if (out_ready) begin
          op_count_d = op_count_q + 8'd1;
          opdec_d    = '0;
          state_d    = S_A;
        end
      end
      default: state_d = S_A;
    endcase
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q    <= S_A;
      a_q        <= '0;
      b_q        <= '0;
      opdec_q    <= '0;
      cnt_q      <= '0;
      result_q   <= '0;
      neg_q      <= 1'b0;
      err_q      <= 1'b0;
      op_count_q <= '0;
    end else begin
      state_q    <= state_d;
      a_q        <= a_d;
      b_q        <= b_d;
      opdec_q    <= opdec_d;
      cnt_q      <= cnt_d;
      result_q   <= result_d;
      neg_q      <= neg_d;
      err_q      <= err_d;
      op_count_q <= op_count_d;
    end
  end

  assign alu_a      = a_q;
  assign alu_b      = b_q;
  assign alu_opdec  = opdec_q;
  assign out_valid  = (state_q == S_RESP);
  assign out_result = result_q;
  assign out_neg    = neg_q;
  assign out_err    = err_q;
  assign busy       = (state_q == S_EXEC) || (state_q == S_RESP);
  assign op_count   = op_count_q;
  assign dbg_state  = state_q;

endmodule

// File: tb/tb_alu_op_sequencer.sv
// Bench for alu_op_sequencer. Two instances are driven from a behavioural ALU stand-in:
// index 0 uses a settle time of 1 cycle and index 1 uses a settle time of 3 cycles.
module tb_alu_op_sequencer;

`ifdef ILLEGAL_OP_TRAP_EN
  localparam bit TRAP_EN = 1'b1;
`else
  localparam bit TRAP_EN = 1'b0;
`endif

  logic        clk = 1'b0;
  logic        reset      [2];
  logic        in_valid   [2];
  logic        in_ready   [2];
  logic [7:0]  in_data    [2];
  logic [7:0]  alu_a      [2];
  logic [7:0]  alu_b      [2];
  logic [15:0] alu_opdec  [2];
  logic        alu_neg    [2];
  logic [3:0]  alu_rl     [2];
  logic [3:0]  alu_rh     [2];
  logic        out_valid  [2];
  logic        out_ready  [2];
  logic [7:0]  out_result [2];
  logic        out_neg    [2];
  logic        out_err    [2];
  logic        busy       [2];
  logic [7:0]  op_count   [2];
  logic [2:0]  dbg_state  [2];

  int          n_checks = 0;
  int          n_errors = 0;
  logic [9:0]  exp_q[$];
  int          cnt_model [2];
  int          exec_of   [2];

  always #5 clk = ~clk;

  alu_op_sequencer #(.EXEC_CYCLES(1)) u_dut_e1 (
    .clk(clk), .reset(reset[0]), .in_valid(in_valid[0]), .in_ready(in_ready[0]),
    .in_data(in_data[0]), .alu_a(alu_a[0]), .alu_b(alu_b[0]), .alu_opdec(alu_opdec[0]),
    .alu_neg(alu_neg[0]), .alu_rl(alu_rl[0]), .alu_rh(alu_rh[0]), .out_valid(out_valid[0]),
    .out_ready(out_ready[0]), .out_result(out_result[0]), .out_neg(out_neg[0]),
    .out_err(out_err[0]), .busy(busy[0]), .op_count(op_count[0]), .dbg_state(dbg_state[0])
  );

  alu_op_sequencer #(.EXEC_CYCLES(3)) u_dut_e3 (
    .clk(clk), .reset(reset[1]), .in_valid(in_valid[1]), .in_ready(in_ready[1]),
    .in_data(in_data[1]), .alu_a(alu_a[1]), .alu_b(alu_b[1]), .alu_opdec(alu_opdec[1]),
    .alu_neg(alu_neg[1]), .alu_rl(alu_rl[1]), .alu_rh(alu_rh[1]), .out_valid(out_valid[1]),
    .out_ready(out_ready[1]), .out_result(out_result[1]), .out_neg(out_neg[1]),
    .out_err(out_err[1]), .busy(busy[1]), .op_count(op_count[1]), .dbg_state(dbg_state[1])
  );

  // ALU behaviour as {neg, result}. Subtract returns the magnitude with neg set when a < b.
  function automatic logic [8:0] alu_fn(input logic [7:0] a, input logic [7:0] b, input int op);
    logic [7:0] r;
    logic       n;
    r = 8'h00;
    n = 1'b0;
    case (op)
      0: r = a + b;
      1: if (a >= b) r = a - b; else begin r = b - a; n = 1'b1; end
      2: r = a & b;
      3: r = a | b;
      4: r = ~a;
      5: r = a << 1;
      6: r = a >> 1;
      7: r = a ^ b;
      8: r = b;
      default: r = 8'h00;
    endcase
    return {n, r};
  endfunction

  // ALU stand-in: responds only to a single clean one-hot code, otherwise idles at 0.
  always_comb begin
    for (int g = 0; g < 2; g++) begin
      logic [8:0] r;
      r = 9'h000;
      for (int i = 0; i < 16; i++)
        if (alu_opdec[g] == (16'd1 << i)) r = alu_fn(alu_a[g], alu_b[g], i);
      alu_neg[g] = r[8];
      alu_rh[g]  = r[7:4];
      alu_rl[g]  = r[3:0];
    end
  end

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", tag, got, exp, $time);
    end
  endtask

  task automatic send_byte(input int d, input logic [7:0] v, input int max_stall);
    int n;
    repeat ($urandom_range(max_stall, 0)) @(negedge clk);
    @(negedge clk);
    in_valid[d] = 1'b1;
    in_data[d]  = v;
    n = 0;
    while (!in_ready[d] && n < 200) begin
      @(negedge clk);
      n++;
    end
    if (n >= 200) check_eq("in_ready_timeout", 32'(n), 32'd0);
    @(posedge clk);
    #1;
    in_valid[d] = 1'b0;
    in_data[d]  = 8'($urandom);
  endtask

  task automatic run_txn(input int d, input logic [7:0] a, input logic [7:0] b,
                         input logic [7:0] op_byte, input int hold);
    int         op;
    bit         illegal;
    logic [8:0] r;
    logic [9:0] e;
    int         lat;
    op      = int'(op_byte[3:0]);
    illegal = TRAP_EN && (op > 8);
    r       = illegal ? 9'h000 : alu_fn(a, b, op);
    exp_q.push_back({illegal, r});
    send_byte(d, a, 2);
    send_byte(d, b, 2);
    send_byte(d, op_byte, 2);
    check_eq("alu_a", 32'(alu_a[d]), 32'(a));
    check_eq("alu_b", 32'(alu_b[d]), 32'(b));
    check_eq("alu_opdec", 32'(alu_opdec[d]), illegal ? 32'd0 : (32'd1 << op));
    lat = 0;
    while (!out_valid[d] && lat < 300) begin
      check_eq("exec_rdy_busy", {30'd0, in_ready[d], busy[d]}, 32'd1);
      @(posedge clk);
      #1;
      lat++;
    end
    check_eq("latency", 32'(lat), illegal ? 32'd0 : 32'(exec_of[d]));
    e = exp_q.pop_front();
    for (int h = 0; h < hold; h++) begin
      @(negedge clk);
      in_valid[d] = 1'($urandom_range(1, 0));
      in_data[d]  = 8'($urandom);
      @(posedge clk);
      #1;
      check_eq("hold_state", {21'd0, out_valid[d], in_ready[d], out_err[d], out_neg[d], out_result[d]},
               {21'd0, 1'b1, 1'b0, e});
    end
    check_eq("out_result", 32'(out_result[d]), 32'(e[7:0]));
    check_eq("out_neg", 32'(out_neg[d]), 32'(e[8]));
    check_eq("out_err", 32'(out_err[d]), 32'(e[9]));
    @(negedge clk);
    in_valid[d]  = 1'b0;
    out_ready[d] = 1'b1;
    @(posedge clk);
    #1;
    out_ready[d] = 1'b0;
    cnt_model[d] = (cnt_model[d] + 1) % 256;
    check_eq("op_count", 32'(op_count[d]), 32'(cnt_model[d]));
    check_eq("post_accept", {29'd0, out_valid[d], in_ready[d], busy[d]}, 32'b010);
    check_eq("opdec_idle", 32'(alu_opdec[d]), 32'd0);
  endtask

  task automatic check_reset_state(input int d);
    check_eq("rst_alu_a", 32'(alu_a[d]), 32'd0);
    check_eq("rst_alu_b", 32'(alu_b[d]), 32'd0);
    check_eq("rst_opdec", 32'(alu_opdec[d]), 32'd0);
    check_eq("rst_result", 32'(out_result[d]), 32'd0);
    check_eq("rst_flags", {28'd0, out_valid[d], out_neg[d], out_err[d], busy[d]}, 32'd0);
    check_eq("rst_op_count", 32'(op_count[d]), 32'd0);
    check_eq("rst_in_ready", 32'(in_ready[d]), 32'd1);
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog: simulation did not complete in time");
    $fatal(1, "watchdog expired");
  end

  initial begin
    exec_of[0] = 1;
    exec_of[1] = 3;
    for (int d = 0; d < 2; d++) begin
      reset[d]     = 1'b1;
      in_valid[d]  = 1'b0;
      in_data[d]   = 8'h00;
      out_ready[d] = 1'b0;
      cnt_model[d] = 0;
    end
    repeat (2) @(posedge clk);
    #1;
    check_reset_state(0);
    check_reset_state(1);
    @(negedge clk);
    reset[0] = 1'b0;
    reset[1] = 1'b0;

    // Directed cases.
    run_txn(0, 8'h25, 8'h13, 8'h00, 0);
    run_txn(0, 8'h05, 8'h09, 8'h01, 2);
    run_txn(1, 8'hF0, 8'h3C, 8'h07, 5);
    run_txn(0, 8'h5A, 8'h33, 8'hAC, 1);
    run_txn(1, 8'h80, 8'h7F, 8'h3F, 3);

    // Random traffic on the slow instance.
    for (int i = 0; i < 40; i++)
      run_txn(1, 8'($urandom), 8'($urandom), 8'($urandom), $urandom_range(3, 0));

    // Random traffic on the fast instance until its counter wraps.
    while (cnt_model[0] != 0)
      run_txn(0, 8'($urandom), 8'($urandom), 8'($urandom), $urandom_range(2, 0));
    check_eq("op_count_wrap", 32'(op_count[0]), 32'd0);

    // Mid-transaction reset after A and B are loaded.
    run_txn(0, 8'h11, 8'h22, 8'h02, 0);
    send_byte(0, 8'h7E, 0);
    send_byte(0, 8'h6D, 0);
    @(negedge clk);
    #2;
    reset[0] = 1'b1;
    #1;
    check_reset_state(0);
    @(negedge clk);
    reset[0]     = 1'b0;
    cnt_model[0] = 0;
    run_txn(0, 8'h01, 8'h01, 8'h00, 1);
    check_eq("fresh_result", 32'(out_result[0]), 32'h02);

    check_eq("scoreboard_empty", 32'(exp_q.size()), 32'd0);
    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
